// File: rtl/hash160_pkg.sv
// Shared encodings and constants for the Hash160 message front end.
package hash160_pkg;

    localparam int BLK_W     = 512;
    localparam int BLK_BYTES = 64;
    localparam int LEN_W     = 64;

    localparam logic [7:0] PAD_BYTE      = 8'h80;
    localparam logic [7:0] START_PAT_DEF = 8'hAA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT,
        ST_PAD
    } state_t;

endpackage

// File: rtl/hash_pad_gen.sv
// Purpose: SHA-256 padding of a partially filled block, or a standalone padding block.
// Latency: combinational.
// Backpressure: none; the packer holds its inputs for as long as needed.
module hash_pad_gen
    import hash160_pkg::*;
#(
    parameter int MSG_BYTES = 64
) (
    input  logic [BLK_W-1:0] data_blk,
    input  logic [6:0]       used,
    input  logic             pad_only,
    input  logic             pad80,
    output logic [BLK_W-1:0] pad_blk,
    output logic             last,
    output logic             pad_pending,
    output logic             pad80_pending
);

    localparam logic [LEN_W-1:0] LEN_BITS = LEN_W'(MSG_BYTES) << 3;
    localparam int LEN_START = BLK_BYTES - LEN_W / 8;

    always_comb begin
        pad_blk       = data_blk;
        last          = 1'b0;
        pad_pending   = 1'b0;
        pad80_pending = 1'b0;
        if (pad_only) begin
            pad_blk = '0;
            if (pad80) begin
                pad_blk[BLK_W-1 -: 8] = PAD_BYTE;
            end
            pad_blk[LEN_W-1:0] = LEN_BITS;
            last = 1'b1;
        end else if (used == 7'(BLK_BYTES)) begin
            // Message ended exactly on a block edge: 0x80 and length go in an extra block.
            pad_pending   = 1'b1;
            pad80_pending = 1'b1;
        end else begin
            for (int i = 0; i < BLK_BYTES; i++) begin
                if (i == int'(used)) begin
                    pad_blk[BLK_W-1-8*i -: 8] = PAD_BYTE;
                end else if (i > int'(used)) begin
                    pad_blk[BLK_W-1-8*i -: 8] = 8'h00;
                end
            end
            if (int'(used) < LEN_START) begin
                pad_blk[LEN_W-1:0] = LEN_BITS;
                last = 1'b1;
            end else begin
                pad_pending = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hash_msg_packer.sv
// Purpose: frames a start-word-delimited stream into SHA-256 padded 512-bit blocks (PACK_BSWAP_EN byte-reverses input words).
// Latency: block valid the cycle after its 64th/final byte is accepted; a trailing pad block 2 cycles after the prior handshake.
// Backpressure: o_ready drops while a block waits for i_block_ready; the block and o_last stay stable until taken.
module hash_msg_packer
    import hash160_pkg::*;
#(
    parameter int         IN_W      = 8,
    parameter int         MSG_BYTES = 64,
    parameter logic [7:0] START_PAT = START_PAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  i_text,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [BLK_W-1:0] o_block,
    output logic             o_block_valid,
    input  logic             i_block_ready,
    output logic             o_last,
    output logic             o_busy
);

    localparam int WB = IN_W / 8;

    state_t           state, state_d;
    logic [BLK_W-1:0] blk_q, blk_d, blk_w, pad_blk;
    logic [6:0]       ptr, ptr_d, new_ptr;
    logic [10:0]      cnt, cnt_d, cnt_nxt;
    logic             last_q, last_d;
    logic             pp_q, pp_d;
    logic             p80_q, p80_d;
    logic             pg_last, pg_pp, pg_p80;
    logic             accept, final_word;

    assign o_ready       = (state == ST_IDLE) || (state == ST_LOAD);
    assign o_block_valid = (state == ST_EMIT);
    assign o_busy        = (state != ST_IDLE);
    assign o_block       = blk_q;
    assign o_last        = last_q;

    assign accept     = i_valid && o_ready;
    assign new_ptr    = ptr + 7'(WB);
    assign cnt_nxt    = cnt + 11'(WB);
    assign final_word = (cnt_nxt == 11'(MSG_BYTES));

    // Pointer is always word aligned, so a word never crosses the block edge.
    always_comb begin
        blk_w = blk_q;
        for (int k = 0; k < WB; k++) begin
`ifdef PACK_BSWAP_EN
            blk_w[BLK_W-1-8*(int'(ptr)+k) -: 8] = i_text[8*k +: 8];
`else
            blk_w[BLK_W-1-8*(int'(ptr)+k) -: 8] = i_text[IN_W-1-8*k -: 8];
`endif
        end
    end

    hash_pad_gen #(
        .MSG_BYTES (MSG_BYTES)
    ) u_pad_gen (
        .data_blk      (blk_w),
        .used          (new_ptr),
        .pad_only      (state == ST_PAD),
        .pad80         (p80_q),
        .pad_blk       (pad_blk),
        .last          (pg_last),
        .pad_pending   (pg_pp),
        .pad80_pending (pg_p80)
    );

    always_comb begin
        state_d = state;
        blk_d   = blk_q;
        ptr_d   = ptr;
        cnt_d   = cnt;
        last_d  = last_q;
        pp_d    = pp_q;
        p80_d   = p80_q;
        unique case (state)
            ST_IDLE: begin
                if (accept && i_text[7:0] == START_PAT) begin
                    state_d = ST_LOAD;
                    blk_d   = '0;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    pp_d    = 1'b0;
                    p80_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_nxt;
                    if (final_word) begin
                        blk_d   = pad_blk;
                        last_d  = pg_last;
                        pp_d    = pg_pp;
                        p80_d   = pg_p80;
                        ptr_d   = '0;
                        state_d = ST_EMIT;
                    end else if (new_ptr == 7'(BLK_BYTES)) begin
                        blk_d   = blk_w;
                        ptr_d   = '0;
                        state_d = ST_EMIT;
                    end else begin
                        blk_d = blk_w;
                        ptr_d = new_ptr;
                    end
                end
            end
            ST_EMIT: begin
                if (i_block_ready) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        last_d  = 1'b0;
                    end else if (pp_q) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_PAD: begin
                blk_d   = pad_blk;
                last_d  = pg_last;
                pp_d    = 1'b0;
                p80_d   = 1'b0;
                state_d = ST_EMIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            blk_q  <= '0;
            ptr    <= '0;
            cnt    <= '0;
            last_q <= 1'b0;
            pp_q   <= 1'b0;
            p80_q  <= 1'b0;
        end else begin
            state  <= state_d;
            blk_q  <= blk_d;
            ptr    <= ptr_d;
            cnt    <= cnt_d;
            last_q <= last_d;
            pp_q   <= pp_d;
            p80_q  <= p80_d;
        end
    end

endmodule

// File: tb/tb_hash_msg_packer.sv
// Bench for hash_msg_packer: five configurations sharing clock, reset and block-ready,
// checked against a byte-queue model of SHA-256 message padding.
module tb_hash_msg_packer;

    typedef struct {
        int           u;
        logic [511:0] b;
        logic         l;
    } cap_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  txt = '0;
    logic [4:0]   vld = '0;
    logic         brdy = 1'b1;
    logic [511:0] blk [5];
    logic [4:0]   bv, lst, bsy, rdy;

    int checks = 0;
    int failures = 0;

    logic [7:0]   msg_q [$];
    logic [511:0] exp_q [$];
    cap_t         caps [$];
    bit           done;

    always #5 clk = ~clk;

    hash_msg_packer #(.IN_W(8), .MSG_BYTES(64)) u_a (
        .clk(clk), .rst_n(rst_n), .i_text(txt[7:0]), .i_valid(vld[0]), .o_ready(rdy[0]),
        .o_block(blk[0]), .o_block_valid(bv[0]), .i_block_ready(brdy), .o_last(lst[0]), .o_busy(bsy[0]));
    hash_msg_packer #(.IN_W(8), .MSG_BYTES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .i_text(txt[7:0]), .i_valid(vld[1]), .o_ready(rdy[1]),
        .o_block(blk[1]), .o_block_valid(bv[1]), .i_block_ready(brdy), .o_last(lst[1]), .o_busy(bsy[1]));
    hash_msg_packer #(.IN_W(8), .MSG_BYTES(56)) u_c (
        .clk(clk), .rst_n(rst_n), .i_text(txt[7:0]), .i_valid(vld[2]), .o_ready(rdy[2]),
        .o_block(blk[2]), .o_block_valid(bv[2]), .i_block_ready(brdy), .o_last(lst[2]), .o_busy(bsy[2]));
    hash_msg_packer #(.IN_W(32), .MSG_BYTES(4)) u_d (
        .clk(clk), .rst_n(rst_n), .i_text(txt[31:0]), .i_valid(vld[3]), .o_ready(rdy[3]),
        .o_block(blk[3]), .o_block_valid(bv[3]), .i_block_ready(brdy), .o_last(lst[3]), .o_busy(bsy[3]));
    hash_msg_packer #(.IN_W(16), .MSG_BYTES(130)) u_e (
        .clk(clk), .rst_n(rst_n), .i_text(txt[15:0]), .i_valid(vld[4]), .o_ready(rdy[4]),
        .o_block(blk[4]), .o_block_valid(bv[4]), .i_block_ready(brdy), .o_last(lst[4]), .o_busy(bsy[4]));

    // A block seen valid with ready at the falling edge is taken on the next rising edge.
    always @(negedge clk) begin
        for (int u = 0; u < 5; u++) begin
            if (rst_n && bv[u] && brdy) caps.push_back('{u: u, b: blk[u], l: lst[u]});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: message, 0x80, zeros to 56 mod 64, then 64-bit big-endian bit length.
    function automatic void build_exp();
        logic [7:0]   p [$];
        logic [63:0]  len;
        logic [511:0] b;
        p = msg_q;
        len = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
        exp_q.delete();
        for (int i = 0; i < p.size(); i += 64) begin
            b = '0;
            for (int j = 0; j < 64; j++) b = {b[503:0], p[i+j]};
            exp_q.push_back(b);
        end
    endfunction

    task automatic send_word(input int u, input logic [31:0] w);
        int n;
        n = 0;
        txt = w;
        vld[u] = 1'b1;
        @(negedge clk);
        while (!rdy[u] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[u]) begin
            failures++;
            $display("FAIL send_timeout u=%0d o_ready=%b required 1", u, rdy[u]);
        end
        @(posedge clk);
        #1;
        vld[u] = 1'b0;
    endtask

    task automatic send_msg(input int u, input int wb, input int gaps);
        logic [31:0] w;
        send_word(u, 32'h0000_00AA);
        for (int k = 0; k < msg_q.size(); k += wb) begin
            w = '0;
            for (int j = 0; j < wb; j++) begin
`ifdef PACK_BSWAP_EN
                w = w | (32'(msg_q[k+j]) << (8*j));
`else
                w = (w << 8) | 32'(msg_q[k+j]);
`endif
            end
            send_word(u, w);
            if (gaps > 0 && k + wb < msg_q.size()) begin
                repeat ($urandom_range(0, gaps)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_caps(input int n, output bit ok);
        int c;
        c = 0;
        while (caps.size() < n && c < 1000) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
        ok = (caps.size() >= n);
    endtask

    task automatic test_reset();
        for (int u = 0; u < 5; u++) begin
            checks++;
            if (blk[u] !== '0 || bv[u] !== 1'b0 || lst[u] !== 1'b0 || bsy[u] !== 1'b0 || rdy[u] !== 1'b1) begin
                failures++;
                $display("FAIL reset_state u=%0d got blk_nonzero=%b valid=%b last=%b busy=%b ready=%b required 0 0 0 0 1",
                         u, |blk[u], bv[u], lst[u], bsy[u], rdy[u]);
            end
        end
    endtask

    task automatic test_full_block();
        bit ok;
        caps.delete();
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'(i));
        build_exp();
        send_msg(0, 1, 0);
        checks++;
        if (bv[0] !== 1'b1) begin
            failures++;
            $display("FAIL case1_latency valid=%b required 1", bv[0]);
        end
        wait_caps(exp_q.size(), ok);
        checks++;
        if (!ok || caps.size() != exp_q.size()) begin
            failures++;
            $display("FAIL case1_count got=%0d required=%0d", caps.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < caps.size(); i++) begin
            checks++;
            if (caps[i].b !== exp_q[i] || caps[i].l !== (i == exp_q.size() - 1) || caps[i].u != 0) begin
                failures++;
                $display("FAIL case1_blk%0d got=%h last=%b required=%h last=%b", i, caps[i].b, caps[i].l,
                         exp_q[i], (i == exp_q.size() - 1));
            end
        end
    endtask

    task automatic test_short_msg();
        bit ok;
        logic [511:0] e;
        e = {24'h616263, 8'h80, 416'h0, 64'h18};
        caps.delete();
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(1, 1, 0);
        checks++;
        if (bv[1] !== 1'b1 || lst[1] !== 1'b1) begin
            failures++;
            $display("FAIL case2_latency valid=%b last=%b required 1 1", bv[1], lst[1]);
        end
        wait_caps(1, ok);
        checks++;
        if (!ok || caps.size() != 1 || caps[0].b !== e || caps[0].l !== 1'b1) begin
            failures++;
            $display("FAIL case2_blk count=%0d got=%h required=%h", caps.size(), ok ? caps[0].b : '0, e);
        end
    endtask

    task automatic test_two_block_pad();
        bit ok;
        caps.delete();
        msg_q.delete();
        for (int i = 0; i < 56; i++) msg_q.push_back(8'(i));
        build_exp();
        send_msg(2, 1, 2);
        wait_caps(exp_q.size(), ok);
        checks++;
        if (!ok || caps.size() != exp_q.size()) begin
            failures++;
            $display("FAIL case3_count got=%0d required=%0d", caps.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < caps.size(); i++) begin
            checks++;
            if (caps[i].b !== exp_q[i] || caps[i].l !== (i == exp_q.size() - 1) || caps[i].u != 2) begin
                failures++;
                $display("FAIL case3_blk%0d got=%h last=%b required=%h", i, caps[i].b, caps[i].l, exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [511:0] hb;
        logic hl;
        caps.delete();
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom_range(0, 255)));
        build_exp();
        brdy = 1'b0;
        send_msg(0, 1, 0);
        hb = blk[0];
        hl = lst[0];
        txt = 32'h0000_00AA;
        vld[0] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (blk[0] !== hb || lst[0] !== hl || rdy[0] !== 1'b0 || bv[0] !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold valid=%b ready=%b last=%b blk_changed=%b required 1 0 %b 0",
                         bv[0], rdy[0], lst[0], blk[0] !== hb, hl);
            end
        end
        vld[0] = 1'b0;
        @(posedge clk);
        #1;
        brdy = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bv[0] !== 1'b0 || bsy[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp_pad_gap valid=%b busy=%b required 0 1", bv[0], bsy[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bv[0] !== 1'b1 || lst[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp_pad_rise valid=%b last=%b required 1 1", bv[0], lst[0]);
        end
        wait_caps(exp_q.size(), ok);
        checks++;
        if (!ok || caps.size() != exp_q.size()) begin
            failures++;
            $display("FAIL bp_count got=%0d required=%0d", caps.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < caps.size(); i++) begin
            checks++;
            if (caps[i].b !== exp_q[i] || caps[i].l !== (i == exp_q.size() - 1)) begin
                failures++;
                $display("FAIL bp_blk%0d got=%h last=%b required=%h", i, caps[i].b, caps[i].l, exp_q[i]);
            end
        end
        checks++;
        if (bsy[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle busy=%b required 0", bsy[0]);
        end
    endtask

    task automatic test_idle_and_reset();
        bit ok;
        caps.delete();
        send_word(0, 32'h55);
        checks++;
        if (bsy[0] !== 1'b0) begin
            failures++;
            $display("FAIL idle_drop55 busy=%b required 0", bsy[0]);
        end
        send_word(0, 32'hAB);
        checks++;
        if (bsy[0] !== 1'b0) begin
            failures++;
            $display("FAIL idle_dropAB busy=%b required 0", bsy[0]);
        end
        send_word(0, 32'hAA);
        checks++;
        if (bsy[0] !== 1'b1) begin
            failures++;
            $display("FAIL idle_start busy=%b required 1", bsy[0]);
        end
        for (int i = 0; i < 20; i++) send_word(0, 32'(8'h11 + 8'(i)));
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (blk[0] !== '0 || bv[0] !== 1'b0 || lst[0] !== 1'b0 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1 || caps.size() != 0) begin
            failures++;
            $display("FAIL midframe_reset blk_nonzero=%b valid=%b last=%b busy=%b ready=%b caps=%0d required 0 0 0 0 1 0",
                     |blk[0], bv[0], lst[0], bsy[0], rdy[0], caps.size());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'(i));
        build_exp();
        send_msg(0, 1, 0);
        wait_caps(exp_q.size(), ok);
        checks++;
        if (!ok || caps.size() != exp_q.size()) begin
            failures++;
            $display("FAIL after_reset_count got=%0d required=%0d", caps.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < caps.size(); i++) begin
            checks++;
            if (caps[i].b !== exp_q[i] || caps[i].l !== (i == exp_q.size() - 1)) begin
                failures++;
                $display("FAIL after_reset_blk%0d got=%h required=%h", i, caps[i].b, exp_q[i]);
            end
        end
    endtask

    task automatic test_wide_word();
        bit ok;
        logic [511:0] e;
`ifdef PACK_BSWAP_EN
        e = {32'h61626364, 8'h80, 408'h0, 64'h20};
`else
        e = {32'h64636261, 8'h80, 408'h0, 64'h20};
`endif
        caps.delete();
        send_word(3, 32'h0000_00AA);
        send_word(3, 32'h6463_6261);
        checks++;
        if (bv[3] !== 1'b1) begin
            failures++;
            $display("FAIL case6_latency valid=%b required 1", bv[3]);
        end
        wait_caps(1, ok);
        checks++;
        if (!ok || caps.size() != 1 || caps[0].b !== e || caps[0].l !== 1'b1) begin
            failures++;
            $display("FAIL case6_blk count=%0d got=%h required=%h", caps.size(), ok ? caps[0].b : '0, e);
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        for (int f = 0; f < 2; f++) begin
            caps.delete();
            msg_q.delete();
            for (int i = 0; i < 130; i++) msg_q.push_back(8'($urandom_range(0, 255)));
            msg_q[5] = 8'hAA;
            build_exp();
            done = 1'b0;
            fork
                begin
                    send_msg(4, 2, 3);
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(posedge clk);
                        #1;
                        brdy = 1'($urandom_range(0, 1));
                    end
                end
            join
            brdy = 1'b1;
            wait_caps(exp_q.size(), ok);
            checks++;
            if (!ok || caps.size() != exp_q.size()) begin
                failures++;
                $display("FAIL rand%0d_count got=%0d required=%0d", f, caps.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < caps.size(); i++) begin
                checks++;
                if (caps[i].b !== exp_q[i] || caps[i].l !== (i == exp_q.size() - 1) || caps[i].u != 4) begin
                    failures++;
                    $display("FAIL rand%0d_blk%0d got=%h last=%b required=%h", f, i, caps[i].b, caps[i].l, exp_q[i]);
                end
            end
            checks++;
            if (bsy[4] !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d_idle busy=%b required 0", f, bsy[4]);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_full_block();
        test_short_msg();
        test_two_block_pad();
        test_backpressure();
        test_idle_and_reset();
        test_wide_word();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
